// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed hex display driver: active-high digit enables, active-low segments,
// per-slot blanking guard and a frame-synchronous double-buffered value.
module seg7_scan_controller #(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic        colon_in,
    output logic        dig3,
    output logic        dig2,
    output logic        dig1,
    output logic        dig0,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        colon,
    output logic        pending,
    output logic        frame_done
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);

    typedef enum logic {BLANK, SHOW} phase_t;

    phase_t        phase, phase_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [1:0]    idx, idx_next;
    logic          slot_end, frame_end;

    logic [15:0] act_val, shd_val;
    logic [3:0]  act_en, shd_en;
    logic        act_colon, shd_colon;

    logic [3:0]  dig_q, dig_next;
    logic [6:0]  seg_q, seg_next;
    logic        colon_q, colon_next;

    // Segment order {a,b,c,d,e,f,g}, 0 = segment lit.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        slot_end   = (cnt == CNT_LAST);
        frame_end  = slot_end && (idx == 2'd3);
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        phase_next = phase;
        if (slot_end) begin
            cnt_next = '0;
            idx_next = idx + 2'd1;
        end
        case (phase)
            BLANK:   if (!slot_end && cnt_next >= CNT_SHOW) phase_next = SHOW;
            default: if (slot_end) phase_next = BLANK;
        endcase
    end

    // Outputs are computed from the next slot state so they land in a register on the
    // same edge the counter moves; active data only changes on a boundary, which is BLANK.
    always_comb begin
        dig_next   = 4'b0000;
        seg_next   = 7'h7F;
        colon_next = 1'b1;
        if (phase_next == SHOW) begin
            if (act_en[idx_next]) dig_next = 4'b0001 << idx_next;
            seg_next   = hex7(act_val[{idx_next, 2'b00} +: 4]);
            colon_next = ~act_colon;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= BLANK;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            phase <= phase_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_val    <= '0;
            act_en     <= '0;
            act_colon  <= 1'b0;
            shd_val    <= '0;
            shd_en     <= '0;
            shd_colon  <= 1'b0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            dig_q      <= 4'b0000;
            seg_q      <= 7'h7F;
            colon_q    <= 1'b1;
        end else begin
            frame_done <= frame_end;
            dig_q      <= dig_next;
            seg_q      <= seg_next;
            colon_q    <= colon_next;
            if (frame_end) begin
                // A load on the boundary edge bypasses the shadow entirely.
                if (load) begin
                    act_val   <= value;
                    act_en    <= digit_en;
                    act_colon <= colon_in;
                    pending   <= 1'b0;
                end else if (pending) begin
                    act_val   <= shd_val;
                    act_en    <= shd_en;
                    act_colon <= shd_colon;
                    pending   <= 1'b0;
                end
            end else if (load) begin
                shd_val   <= value;
                shd_en    <= digit_en;
                shd_colon <= colon_in;
                pending   <= 1'b1;
            end
        end
    end

    assign {dig3, dig2, dig1, dig0} = dig_q;
    assign {a, b, c, d, e, f, g}    = seg_q;
    assign colon                    = colon_q;
endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller with TICK_DIV=8, BLANK_CYC=2 (32-cycle frames);
// each cycle's digit/segment/colon outputs are compared against hand-coded glyph tables.
module tb_seg7_scan_controller;
    logic        clk, rst, load, colon_in;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic        dig3, dig2, dig1, dig0, a, b, c, d, e, f, g, colon, pending, frame_done;

    seg7_scan_controller #(.TICK_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .digit_en(digit_en),
        .colon_in(colon_in), .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .colon(colon),
        .pending(pending), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      en;
        logic            col;
        logic [3:0][6:0] seg;  // expected active-low glyph per slot
    } vec_t;

    vec_t vecs[4];
    vec_t cur, v0, v1, v2, v3;
    int   cyc, total, passed;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    endtask

    function automatic logic [11:0] exp_out(input vec_t v, input int pos);
        int slot, cn;
        logic [3:0] dg;
        slot = pos / 8;
        cn   = pos % 8;
        if (cn < 2) return {4'b0000, 7'h7F, 1'b1};
        dg = v.en[slot] ? (4'b0001 << slot) : 4'b0000;
        return {dg, v.seg[slot], ~v.col};
    endfunction

    task automatic step_check();
        int pos;
        @(posedge clk);
        #1;
        cyc++;
        pos = cyc % 32;
        chk("outputs", {4'b0, dig3, dig2, dig1, dig0, a, b, c, d, e, f, g, colon},
            {4'b0, exp_out(cur, pos)});
        chk("frame_done", {15'b0, frame_done}, {15'b0, (pos == 0)});
    endtask

    task automatic run_until(input int pos);
        while (cyc % 32 != pos) step_check();
    endtask

    task automatic do_load(input vec_t v);
        value    = v.val;
        digit_en = v.en;
        colon_in = v.col;
        load     = 1'b1;
        step_check();
        load     = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int lp);
        run_until(lp);
        do_load(v);
        chk("pending_set", {15'b0, pending}, 16'd1);
        while (cyc % 32 != 0) begin
            step_check();
            chk("pending_hold", {15'b0, pending}, {15'b0, (cyc % 32 != 0)});
        end
        cur = v;
        repeat (32) step_check();
    endtask

    initial begin
        total = 0; passed = 0; cyc = 0;
        load = 0; value = '0; digit_en = '0; colon_in = 0;
        vecs[0] = '{val: 16'h1234, en: 4'hF, col: 1'b0,
                    seg: {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
        vecs[1] = '{val: 16'hABCD, en: 4'hF, col: 1'b1,
                    seg: {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010}};
        vecs[2] = '{val: 16'h5E60, en: 4'b0101, col: 1'b0,
                    seg: {7'b0100100, 7'b0110000, 7'b0100000, 7'b0000001}};
        vecs[3] = '{val: 16'hF987, en: 4'b1010, col: 1'b1,
                    seg: {7'b0111000, 7'b0000100, 7'b0000000, 7'b0001111}};
        v0 = '{val: 16'h0000, en: 4'h0, col: 1'b0, seg: {4{7'b0000001}}};
        v1 = '{val: 16'h1111, en: 4'hF, col: 1'b0, seg: {4{7'b1001111}}};
        v2 = '{val: 16'h2222, en: 4'hF, col: 1'b1, seg: {4{7'b0010010}}};
        v3 = '{val: 16'h3333, en: 4'hF, col: 1'b0, seg: {4{7'b0000110}}};
        cur = v0;

        rst = 1'b1;
        #12;
        chk("reset_outputs", {4'b0, dig3, dig2, dig1, dig0, a, b, c, d, e, f, g, colon},
            {4'b0, 4'b0000, 7'h7F, 1'b1});
        chk("reset_flags", {14'b0, pending, frame_done}, 16'd0);
        #11 rst = 1'b0;  // t=23, next posedge at 25

        // Table: mid-frame load, old data persists to the boundary, new data next frame.
        for (int i = 0; i < 4; i++) apply_vec(vecs[i], 10);

        // Three loads in one frame: only the last reaches the display.
        run_until(4);  do_load(v1);
        run_until(12); do_load(v2);
        run_until(20); do_load(v3);
        chk("pending_multi", {15'b0, pending}, 16'd1);
        run_until(0);
        chk("pending_multi_clr", {15'b0, pending}, 16'd0);
        cur = v3;
        repeat (32) step_check();

        // Load on the boundary edge goes straight to active.
        run_until(31);
        do_load(vecs[1]);
        chk("pending_coincident", {15'b0, pending}, 16'd0);
        cur = vecs[1];
        repeat (32) begin
            step_check();
            chk("pending_never", {15'b0, pending}, 16'd0);
        end

        // Reset during SHOW with data pending.
        run_until(1);
        do_load(vecs[0]);
        run_until(20);
        chk("pre_reset_dig2", {15'b0, dig2}, 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_out", {4'b0, dig3, dig2, dig1, dig0, a, b, c, d, e, f, g, colon},
            {4'b0, 4'b0000, 7'h7F, 1'b1});
        chk("async_reset_pend", {15'b0, pending}, 16'd0);
        #2 rst = 1'b0;
        cyc = 0;
        cur = v0;
        step_check();
        chk("restart_cyc1_blank", {9'b0, a, b, c, d, e, f, g}, 16'h007F);
        step_check();
        chk("restart_cyc2_show", {9'b0, a, b, c, d, e, f, g}, 16'h0001);
        apply_vec(vecs[0], 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
